// File: rtl/serial_addsub_digit.sv
// rtl/serial_addsub_digit.sv - digit-serial adder/subtractor, LSD first, one-cycle registered result
module serial_addsub_digit #(
    parameter int DIGIT_W   = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               last,
    input  logic               sub,
    output logic               sum_vld,
    output logic [DIGIT_W-1:0] sum,
    output logic               sum_last,
    output logic               cout,
    output logic               ovf,
    output logic               err
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               carry_q, carry_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sum_vld_q, sum_vld_d;
    logic [DIGIT_W-1:0] sum_q, sum_d;
    logic               sum_last_q, sum_last_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic               mode_eff;
    logic               cin;
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   full;
    logic               c_out;
    logic               c_msb;
    logic               term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            carry_q    <= 1'b0;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            sum_vld_q  <= 1'b0;
            sum_q      <= '0;
            sum_last_q <= 1'b0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            carry_q    <= carry_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            sum_vld_q  <= sum_vld_d;
            sum_q      <= sum_d;
            sum_last_q <= sum_last_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        // The first beat of an operand takes its mode and carry-in straight from sub.
        mode_eff = (state_q == IDLE) ? sub : mode_q;
        cin      = (state_q == IDLE) ? sub : carry_q;
        b_eff    = mode_eff ? ~b : b;
        full     = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
        c_out    = full[DIGIT_W];
        c_msb    = full[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];
        term     = last | (cnt_q == CNT_W'(MAX_BEATS - 1));

        state_d    = state_q;
        carry_d    = carry_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        sum_vld_d  = 1'b0;
        sum_d      = sum_q;
        sum_last_d = 1'b0;
        cout_d     = 1'b0;
        ovf_d      = 1'b0;
        err_d      = 1'b0;

        if (vld) begin
            sum_vld_d  = 1'b1;
            sum_d      = full[DIGIT_W-1:0];
            sum_last_d = term;
            cout_d     = term & c_out;
            ovf_d      = term & (c_msb ^ c_out);
            err_d      = term & ~last;
            if (term) begin
                state_d = IDLE;
                carry_d = 1'b0;
                cnt_d   = '0;
            end else begin
                state_d = RUN;
                carry_d = c_out;
                cnt_d   = cnt_q + CNT_W'(1);
                mode_d  = mode_eff;
            end
        end
    end

    assign sum_vld  = sum_vld_q;
    assign sum      = sum_q;
    assign sum_last = sum_last_q;
    assign cout     = cout_q;
    assign ovf      = ovf_q;
    assign err      = err_q;

endmodule

// File: doc/serial_addsub_digit.md
Name: serial_addsub_digit

Overview:
Parametrised digit-serial adder/subtractor; successor to the single-bit serial adder with valid. Each valid beat carries one DIGIT_W-bit digit of each operand, least-significant digit first, and the operand closes on `last`. Adds a per-operand add/subtract mode, registered outputs, final carry and signed-overflow flags, and a beat-count guard. Sits in datapaths that stream wide operands over narrow buses.

Parameters:
DIGIT_W, 4, bits per beat (>=2)
MAX_BEATS, 16, maximum digits per operand; the beat counter is $clog2(MAX_BEATS+1) bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset: asserted at 0, released synchronously to clk by the integrator
vld  input  1  input beat valid
a  input  DIGIT_W  operand A digit
b  input  DIGIT_W  operand B digit
last  input  1  final (most-significant) digit of this operand
sub  input  1  mode: 1 = A-B, 0 = A+B; sampled on the first beat only
sum_vld  output  1  output beat valid
sum  output  DIGIT_W  result digit
sum_last  output  1  final digit of the result
cout  output  1  final carry-out; for subtract, 1 = no borrow; valid when sum_last=1, else 0
ovf  output  1  two's-complement overflow; valid when sum_last=1, else 0
err  output  1  operand exceeded MAX_BEATS without `last`; valid when sum_last=1, else 0

Behaviour:
- State: IDLE (expecting first beat) and RUN (mid-operand). Internal regs: carry, mode, beat_cnt.
- Reset (rst=0, asynchronous):
  - State=IDLE, carry=0, mode=0, beat_cnt=0.
  - All outputs 0, including sum.
- Beat accepted when vld=1; vld=0 cycles are bubbles with no state change.
- Mode and carry-in per beat:
  - IDLE beat: mode_eff=sub, cin=sub.
  - RUN beat: mode_eff=mode register, cin=carry register. Changes on `sub` mid-operand are ignored.
- Arithmetic: b_eff = mode_eff ? ~b : b; {c_out, s} = a + b_eff + cin, computed at DIGIT_W+1 bits.
- Latency: exactly 1 cycle. On the clock edge of an accepted beat:
  - sum<=s, sum_vld<=1.
  - sum_last<=term.
  - cout<=term & c_out.
  - ovf<=term & (carry into bit DIGIT_W-1 XOR c_out).
  - err<=term & ~last.
- Termination: term = last | (beat_cnt == MAX_BEATS-1). The MAX_BEATS-th beat without `last` is forced to terminate the operand.
- On term:
  - carry<=0, beat_cnt<=0, state<=IDLE.
  - The next accepted beat starts a new operand, so back-to-back operands need no idle cycle.
- On a non-term beat: carry<=c_out, beat_cnt<=beat_cnt+1, state<=RUN, mode<=mode_eff.
- On a bubble cycle (vld=0):
  - sum_vld, sum_last, cout, ovf, err <= 0.
  - sum holds its last value.
  - carry, mode, beat_cnt and state hold.
- `last` is ignored when vld=0.
- Single-beat operands (last on the first beat) are legal: cin=sub and term apply on the same beat.
- Reset asserted mid-operand aborts it. No partial sum_last is produced, and the next beat after release is treated as a first beat.

Test Plan:
1. DIGIT_W=4, add A=0x00FF, B=0x0001 over 4 beats (digits LSD first: a=F,F,0,0; b=1,0,0,0; last on beat 4) -> sum digits 0,0,1,0; sum_last only on digit 4; cout=0, ovf=0, err=0; each digit appears 1 cycle after its input beat.
2. Single beat, sub=1, a=3, b=5, last=1 -> sum=0xE, cout=0 (borrow), ovf=0; sub=1, a=8, b=1 -> sum=7, cout=1, ovf=1.
3. Single beat, sub=0, a=7, b=1, last=1 -> sum=8, ovf=1, cout=0; then a=F, b=1 -> sum=0, cout=1, ovf=0.
4. Two-beat add a=F,F b=1,0 with 3 vld=0 cycles between beats, and sub toggled to 1 during the gap -> carry and add mode preserved: sum digits 0,0, cout=1; sum_vld low during the gap and sum held at 0.
5. MAX_BEATS=4, 5 consecutive beats with last=0 -> beat 4 output has sum_last=1, err=1; beat 5 starts a new operand with cin=sub.
6. Async reset: beat 1 of a=F, b=1 (carry=1), then drive rst low between edges -> all outputs 0 immediately, with no clock edge required; after release, a single beat a=1, b=1, last=1 -> sum=2, cout=0 (stale carry not used).
